// File: rtl/modmap_pkg.sv
// rtl/modmap_pkg.sv - shared constants, FSM state type and subcarrier-limit helper
//
// Purpose : sample format (Q4.12), constellation amplitudes, collector state
//           enum and the n_sc -> block-length mapping used by modmap_sipo_tx.
// Ports   : none (package).
// Macro   : MODMAP_SINGLE_TONE_EN makes n_sc = 2'b11 select a 1-entry block.
package modmap_pkg;
    localparam int FRAC_WIDTH = 12;
    localparam int INT_WIDTH  = 4;
    localparam int DATA_WIDTH = INT_WIDTH + FRAC_WIDTH;
    localparam int N_ENTRIES  = 12;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    // ~1/sqrt(2) and 1.0 in Q4.12
    localparam sample_t QPSK_AMP = sample_t'(2896);
    localparam sample_t UNIT_AMP = sample_t'(1 << FRAC_WIDTH);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    function automatic logic [3:0] n_sc_to_limit(input logic [1:0] n_sc);
        case (n_sc)
            2'b00:   return 4'd3;
            2'b01:   return 4'd6;
`ifdef MODMAP_SINGLE_TONE_EN
            2'b11:   return 4'd1;
`endif
            default: return 4'd12;
        endcase
    endfunction
endpackage

// File: rtl/modmap_sipo_tx_if.sv
// rtl/modmap_sipo_tx_if.sv - bit-stream in / symbol-block out bundle
//
// Purpose : groups the frame-control, serial-bit handshake and parallel block
//           outputs of modmap_sipo_tx.
// Ports   : i_start, i_Qm[2:0], i_n_sc[1:0], i_bit, i_bit_valid (to block);
//           o_bit_ready, o_X_re[0:11], o_X_im[0:11], o_valid (from block).
// Modports: master = bit source / DFT side, slave = modmap_sipo_tx.
interface modmap_sipo_tx_if;
    import modmap_pkg::*;

    logic        i_start;
    logic [2:0]  i_Qm;
    logic [1:0]  i_n_sc;
    logic        i_bit;
    logic        i_bit_valid;
    logic        o_bit_ready;
    sample_t     o_X_re [0:N_ENTRIES-1];
    sample_t     o_X_im [0:N_ENTRIES-1];
    logic        o_valid;

    modport master (
        output i_start, i_Qm, i_n_sc, i_bit, i_bit_valid,
        input  o_bit_ready, o_X_re, o_X_im, o_valid
    );

    modport slave (
        input  i_start, i_Qm, i_n_sc, i_bit, i_bit_valid,
        output o_bit_ready, o_X_re, o_X_im, o_valid
    );
endinterface

// File: rtl/modmap_sym.sv
// rtl/modmap_sym.sv - combinational BPSK/QPSK constellation mapper
//
// Purpose : maps one symbol's bits to a Q4.12 (re, im) point.
// Ports   : bpsk   - 1 = BPSK (b1 only), 0 = QPSK (b0 -> I sign, b1 -> Q sign)
//           b0, b1 - symbol bits (b0 ignored for BPSK)
//           rotate - (MODMAP_SINGLE_TONE_EN only) odd-parity symbol rotation
//           re, im - mapped point
// Macro   : MODMAP_SINGLE_TONE_EN adds the pi/2-BPSK / pi/4-QPSK rotation.
module modmap_sym
    import modmap_pkg::*;
(
    input  logic    bpsk,
    input  logic    b0,
    input  logic    b1,
`ifdef MODMAP_SINGLE_TONE_EN
    input  logic    rotate,
`endif
    output sample_t re,
    output sample_t im
);
    sample_t base_re;
    sample_t base_im;

    always_comb begin
        if (bpsk) begin
            base_re = b1 ? -QPSK_AMP : QPSK_AMP;
            base_im = base_re;
        end else begin
            base_re = b0 ? -QPSK_AMP : QPSK_AMP;
            base_im = b1 ? -QPSK_AMP : QPSK_AMP;
        end
    end

`ifdef MODMAP_SINGLE_TONE_EN
    // BPSK: multiply by j. QPSK: +pi/4 moves diagonal points onto the axes,
    // equal signs land on the imaginary axis, opposite signs on the real axis.
    always_comb begin
        re = base_re;
        im = base_im;
        if (rotate) begin
            if (bpsk) begin
                re = -base_im;
                im = base_re;
            end else if (base_re == base_im) begin
                re = '0;
                im = base_re[DATA_WIDTH-1] ? -UNIT_AMP : UNIT_AMP;
            end else begin
                re = base_re[DATA_WIDTH-1] ? -UNIT_AMP : UNIT_AMP;
                im = '0;
            end
        end
    end
`else
    assign re = base_re;
    assign im = base_im;
`endif
endmodule

// File: rtl/modmap_sipo_tx.sv
// rtl/modmap_sipo_tx.sv - serial bits -> mapped symbols -> parallel DFT block
//
// Purpose : collects Qm-bit groups from a serial stream, maps them to
//           BPSK/QPSK points and presents a 3/6/12-entry block with a
//           one-cycle o_valid pulse for the downstream transform precoder.
// Ports   : i_clk - rising-edge clock
//           i_rst - synchronous active-high reset (priority over i_start)
//           bus   - modmap_sipo_tx_if.slave (config, bit handshake, block out)
// Macro   : MODMAP_SINGLE_TONE_EN enables n_sc = 2'b11 single-tone mode with
//           parity-based symbol rotation; otherwise 2'b11 behaves as 12.
module modmap_sipo_tx
    import modmap_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    modmap_sipo_tx_if.slave  bus
);
    state_t      state;
    logic        bpsk_q;
    logic [1:0]  n_sc_q;
    logic [3:0]  sym_idx;
    logic        half_q;     // QPSK b0 held, waiting for b1
    logic        b0_q;
    sample_t     shadow_re [0:N_ENTRIES-1];
    sample_t     shadow_im [0:N_ENTRIES-1];
    sample_t     sym_re;
    sample_t     sym_im;
    logic [3:0]  limit;
    logic        accept;
    logic        sym_done;
    logic        block_done;

    assign limit = n_sc_to_limit(n_sc_q);

    // i_start wins over a same-cycle bit: the bit belongs to the discarded frame.
    assign accept     = (state == ST_COLLECT) && bus.i_bit_valid && !bus.i_start;
    assign sym_done   = accept && (bpsk_q || half_q);
    assign block_done = sym_done && (sym_idx == limit - 4'd1);

`ifdef MODMAP_SINGLE_TONE_EN
    logic parity_q;
    logic single_tone;
    assign single_tone = (n_sc_q == 2'b11);
`endif

    modmap_sym u_sym (
        .bpsk   (bpsk_q),
        .b0     (b0_q),
        .b1     (bus.i_bit),
`ifdef MODMAP_SINGLE_TONE_EN
        .rotate (single_tone && parity_q),
`endif
        .re     (sym_re),
        .im     (sym_im)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            bus.o_bit_ready <= 1'b0;
            bus.o_valid     <= 1'b0;
            bpsk_q          <= 1'b0;
            n_sc_q          <= 2'b00;
            sym_idx         <= 4'd0;
            half_q          <= 1'b0;
            b0_q            <= 1'b0;
`ifdef MODMAP_SINGLE_TONE_EN
            parity_q        <= 1'b0;
`endif
            for (int i = 0; i < N_ENTRIES; i++) begin
                shadow_re[i]  <= '0;
                shadow_im[i]  <= '0;
                bus.o_X_re[i] <= '0;
                bus.o_X_im[i] <= '0;
            end
        end else begin
            bus.o_valid <= 1'b0;
            if (bus.i_start) begin
                state           <= ST_COLLECT;
                bus.o_bit_ready <= 1'b1;
                bpsk_q          <= (bus.i_Qm == 3'd1);
                n_sc_q          <= bus.i_n_sc;
                sym_idx         <= 4'd0;
                half_q          <= 1'b0;
`ifdef MODMAP_SINGLE_TONE_EN
                parity_q        <= 1'b0;
`endif
            end else if (accept) begin
                if (!sym_done) begin
                    half_q <= 1'b1;
                    b0_q   <= bus.i_bit;
                end else begin
                    half_q             <= 1'b0;
                    shadow_re[sym_idx] <= sym_re;
                    shadow_im[sym_idx] <= sym_im;
`ifdef MODMAP_SINGLE_TONE_EN
                    parity_q           <= ~parity_q;
`endif
                    if (block_done) begin
                        // The last symbol is still in flight, so it bypasses the shadow.
                        sym_idx     <= 4'd0;
                        bus.o_valid <= 1'b1;
                        for (int i = 0; i < N_ENTRIES; i++) begin
                            if (4'(i) >= limit) begin
                                bus.o_X_re[i] <= '0;
                                bus.o_X_im[i] <= '0;
                            end else if (4'(i) == sym_idx) begin
                                bus.o_X_re[i] <= sym_re;
                                bus.o_X_im[i] <= sym_im;
                            end else begin
                                bus.o_X_re[i] <= shadow_re[i];
                                bus.o_X_im[i] <= shadow_im[i];
                            end
                        end
                    end else begin
                        sym_idx <= sym_idx + 4'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_modmap_sipo_tx.sv
// tb/tb_modmap_sipo_tx.sv - self-checking bench for modmap_sipo_tx
`timescale 1ns/1ps
module tb_modmap_sipo_tx;
    import modmap_pkg::*;

    localparam int  A  = 2896;
    localparam real PI = 3.14159265358979;

    typedef int blk_t [12];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    modmap_sipo_tx_if bus();

    modmap_sipo_tx dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_bit_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    blk_t got_re[$];
    blk_t got_im[$];
    int   got_cyc[$];
    bit   got_rdy[$];
    blk_t exp_re[$];
    blk_t exp_im[$];

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            blk_t r;
            blk_t m;
            for (int i = 0; i < 12; i++) begin
                r[i] = int'(bus.o_X_re[i]);
                m[i] = int'(bus.o_X_im[i]);
            end
            got_re.push_back(r);
            got_im.push_back(m);
            got_cyc.push_back(cyc);
            got_rdy.push_back(bus.o_bit_ready === 1'b1);
        end
    end

    // Reference model: symbol list from the mapping rules, then chop into blocks.
    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic void model(input bit bits[$], input int qm, input int nsc);
        int sre[$];
        int sim[$];
        int lim;
        exp_re.delete();
        exp_im.delete();
        if (qm == 1) begin
            foreach (bits[k]) begin
                sre.push_back(bits[k] ? -A : A);
                sim.push_back(bits[k] ? -A : A);
            end
        end else begin
            for (int k = 0; k + 1 < bits.size(); k += 2) begin
                sre.push_back(bits[k]     ? -A : A);
                sim.push_back(bits[k + 1] ? -A : A);
            end
        end
        lim = (nsc == 0) ? 3 : (nsc == 1) ? 6 : 12;
`ifdef MODMAP_SINGLE_TONE_EN
        if (nsc == 3) begin
            lim = 1;
            for (int p = 1; p < sre.size(); p += 2) begin
                int t;
                real ang;
                if (qm == 1) begin
                    t = sre[p];
                    sre[p] = -sim[p];
                    sim[p] = t;
                end else begin
                    ang = $atan2(real'(sim[p]), real'(sre[p])) + PI / 4.0;
                    sre[p] = rnd(4096.0 * $cos(ang));
                    sim[p] = rnd(4096.0 * $sin(ang));
                end
            end
        end
`endif
        for (int b = 0; (b + 1) * lim <= sre.size(); b++) begin
            blk_t r;
            blk_t m;
            for (int i = 0; i < 12; i++) begin
                r[i] = (i < lim) ? sre[b * lim + i] : 0;
                m[i] = (i < lim) ? sim[b * lim + i] : 0;
            end
            exp_re.push_back(r);
            exp_im.push_back(m);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_re.delete();
        got_im.delete();
        got_cyc.delete();
        got_rdy.delete();
    endtask

    task automatic do_start(input int qm, input int nsc, input bit with_bit);
        bus.i_start     = 1'b1;
        bus.i_Qm        = 3'(qm);
        bus.i_n_sc      = 2'(nsc);
        bus.i_bit_valid = with_bit;
        bus.i_bit       = 1'($urandom);
        step();
        bus.i_start     = 1'b0;
        bus.i_bit_valid = 1'b0;
    endtask

    task automatic send_bits(input bit bits[$], input int max_gap, input bit scramble);
        foreach (bits[k]) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                bus.i_bit_valid = 1'b0;
                bus.i_bit       = 1'($urandom);
                if (scramble) begin
                    bus.i_Qm   = 3'($urandom);
                    bus.i_n_sc = 2'($urandom);
                end
                step();
            end
            bus.i_bit_valid = 1'b1;
            bus.i_bit       = bits[k];
            if (scramble) begin
                bus.i_Qm   = 3'($urandom);
                bus.i_n_sc = 2'($urandom);
            end
            last_bit_cyc = cyc;
            step();
        end
        bus.i_bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit zero_ok;
        zero_ok = 1'b1;
        for (int i = 0; i < 12; i++)
            if (bus.o_X_re[i] !== '0 || bus.o_X_im[i] !== '0) zero_ok = 1'b0;
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset o_valid: got %b expected 0", bus.o_valid);
        end
        n_cmp++;
        if (bus.o_bit_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset o_bit_ready: got %b expected 0", bus.o_bit_ready);
        end
        n_cmp++;
        if (!zero_ok) begin
            n_err++;
            $display("FAIL reset outputs: got re0=%0d im0=%0d expected all 0", bus.o_X_re[0], bus.o_X_im[0]);
        end
    endtask

    task automatic test_qpsk_short();
        bit bits[$];
        blk_t er;
        blk_t ei;
        bits = '{0, 0, 0, 1, 1, 1};
        er = '{A, A, -A, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ei = '{A, -A, -A, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        clear_mon();
        do_start(2, 0, 1'b0);
        send_bits(bits, 0, 1'b0);
        repeat (3) step();
        n_cmp++;
        if (got_re.size() != 1) begin
            n_err++;
            $display("FAIL qpsk_short pulses: got %0d expected 1", got_re.size());
        end else begin
            n_cmp++;
            if (got_cyc[0] != last_bit_cyc + 1) begin
                n_err++;
                $display("FAIL qpsk_short latency: got cycle %0d expected %0d", got_cyc[0], last_bit_cyc + 1);
            end
            n_cmp++;
            if (got_re[0] != er || got_im[0] != ei) begin
                n_err++;
                $display("FAIL qpsk_short block: got re=%p im=%p expected re=%p im=%p", got_re[0], got_im[0], er, ei);
            end
        end
    endtask

    task automatic test_bpsk_back_to_back();
        bit bits[$];
        for (int k = 0; k < 24; k++) bits.push_back(1'(k & 1));
        model(bits, 1, 2);
        clear_mon();
        do_start(1, 2, 1'b0);
        send_bits(bits, 0, 1'b0);
        repeat (3) step();
        n_cmp++;
        if (got_re.size() != 2) begin
            n_err++;
            $display("FAIL b2b pulses: got %0d expected 2", got_re.size());
        end else begin
            n_cmp++;
            if (got_cyc[1] - got_cyc[0] != 12 || got_cyc[1] != last_bit_cyc + 1) begin
                n_err++;
                $display("FAIL b2b timing: got cycles %0d,%0d expected spacing 12 ending %0d", got_cyc[0], got_cyc[1], last_bit_cyc + 1);
            end
            n_cmp++;
            if (got_rdy[0] !== 1'b1 || got_rdy[1] !== 1'b1) begin
                n_err++;
                $display("FAIL b2b ready at pulse: got %b%b expected 11", got_rdy[0], got_rdy[1]);
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (got_re[k] != exp_re[k] || got_im[k] != exp_im[k]) begin
                    n_err++;
                    $display("FAIL b2b block %0d: got re=%p im=%p expected re=%p im=%p", k, got_re[k], got_im[k], exp_re[k], exp_im[k]);
                end
            end
        end
    endtask

    task automatic test_qpsk_gaps();
        bit first[$];
        bit rest[$];
        bit all[$];
        for (int k = 0; k < 12; k++) all.push_back(1'($urandom));
        first.push_back(all[0]);
        for (int k = 1; k < 12; k++) rest.push_back(all[k]);
        model(all, 2, 1);
        clear_mon();
        do_start(2, 1, 1'b0);
        send_bits(first, 0, 1'b0);
        repeat (3) begin
            bus.i_bit = 1'($urandom);
            step();
        end
        send_bits(rest, 3, 1'b0);
        repeat (3) step();
        n_cmp++;
        if (got_re.size() != 1) begin
            n_err++;
            $display("FAIL gaps pulses: got %0d expected 1", got_re.size());
        end else begin
            n_cmp++;
            if (got_re[0] != exp_re[0] || got_im[0] != exp_im[0]) begin
                n_err++;
                $display("FAIL gaps block: got re=%p im=%p expected re=%p im=%p", got_re[0], got_im[0], exp_re[0], exp_im[0]);
            end
        end
    endtask

    // Expects the outputs to still hold the last expected block from the caller.
    task automatic test_restart();
        bit part[$];
        bit bits[$];
        blk_t prev_re;
        blk_t prev_im;
        blk_t cur_re;
        blk_t cur_im;
        prev_re = exp_re[exp_re.size() - 1];
        prev_im = exp_im[exp_im.size() - 1];
        for (int k = 0; k < 8; k++) part.push_back(1'($urandom));
        clear_mon();
        do_start(2, 1, 1'b0);
        send_bits(part, 1, 1'b0);
        do_start(2, 1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cur_re[i] = int'(bus.o_X_re[i]);
            cur_im[i] = int'(bus.o_X_im[i]);
        end
        n_cmp++;
        if (got_re.size() != 0) begin
            n_err++;
            $display("FAIL restart spurious pulse: got %0d expected 0", got_re.size());
        end
        n_cmp++;
        if (cur_re != prev_re || cur_im != prev_im) begin
            n_err++;
            $display("FAIL restart hold: got re=%p expected re=%p", cur_re, prev_re);
        end
        for (int k = 0; k < 12; k++) bits.push_back(1'($urandom));
        model(bits, 2, 1);
        send_bits(bits, 1, 1'b1);
        repeat (3) step();
        n_cmp++;
        if (got_re.size() != 1) begin
            n_err++;
            $display("FAIL restart pulses: got %0d expected 1", got_re.size());
        end else begin
            n_cmp++;
            if (got_re[0] != exp_re[0] || got_im[0] != exp_im[0]) begin
                n_err++;
                $display("FAIL restart block: got re=%p im=%p expected re=%p im=%p", got_re[0], got_im[0], exp_re[0], exp_im[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit part[$];
        bit bits[$];
        bit zero_ok;
        for (int k = 0; k < 10; k++) part.push_back(1'($urandom));
        do_start(2, 2, 1'b0);
        send_bits(part, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        zero_ok = 1'b1;
        for (int i = 0; i < 12; i++)
            if (bus.o_X_re[i] !== '0 || bus.o_X_im[i] !== '0) zero_ok = 1'b0;
        n_cmp++;
        if (!zero_ok || bus.o_valid !== 1'b0 || bus.o_bit_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got valid=%b ready=%b re0=%0d expected 0/0/0", bus.o_valid, bus.o_bit_ready, bus.o_X_re[0]);
        end
        for (int k = 0; k < 12; k++) bits.push_back(1'($urandom));
        model(bits, 2, 1);
        clear_mon();
        do_start(2, 1, 1'b0);
        send_bits(bits, 2, 1'b0);
        repeat (3) step();
        n_cmp++;
        if (got_re.size() != 1) begin
            n_err++;
            $display("FAIL reset_mid resume pulses: got %0d expected 1", got_re.size());
        end else begin
            n_cmp++;
            if (got_re[0] != exp_re[0] || got_im[0] != exp_im[0]) begin
                n_err++;
                $display("FAIL reset_mid resume block: got re=%p im=%p expected re=%p im=%p", got_re[0], got_im[0], exp_re[0], exp_im[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            bit bits[$];
            int qm;
            int nsc;
            int nb;
            qm  = int'($urandom_range(0, 7));
            nsc = int'($urandom_range(0, 3));
            nb  = int'($urandom_range(0, 40));
            for (int k = 0; k < nb; k++) bits.push_back(1'($urandom));
            model(bits, qm, nsc);
            clear_mon();
            do_start(qm, nsc, 1'b1);
            send_bits(bits, 2, 1'b1);
            repeat (3) step();
            n_cmp++;
            if (got_re.size() != exp_re.size()) begin
                n_err++;
                $display("FAIL random r%0d qm=%0d nsc=%0d pulses: got %0d expected %0d", r, qm, nsc, got_re.size(), exp_re.size());
            end else begin
                foreach (exp_re[k]) begin
                    n_cmp++;
                    if (got_re[k] != exp_re[k] || got_im[k] != exp_im[k]) begin
                        n_err++;
                        $display("FAIL random r%0d block %0d: got re=%p im=%p expected re=%p im=%p", r, k, got_re[k], got_im[k], exp_re[k], exp_im[k]);
                    end
                end
            end
        end
    endtask

`ifdef MODMAP_SINGLE_TONE_EN
    task automatic test_single_tone();
        bit bits[$];
        bits = '{0, 0};
        clear_mon();
        do_start(1, 3, 1'b0);
        send_bits(bits, 0, 1'b0);
        repeat (3) step();
        n_cmp++;
        if (got_re.size() != 2) begin
            n_err++;
            $display("FAIL single_tone pulses: got %0d expected 2", got_re.size());
        end else begin
            n_cmp++;
            if (got_re[0][0] != A || got_im[0][0] != A || got_re[1][0] != -A || got_im[1][0] != A) begin
                n_err++;
                $display("FAIL single_tone points: got (%0d,%0d),(%0d,%0d) expected (%0d,%0d),(%0d,%0d)", got_re[0][0], got_im[0][0], got_re[1][0], got_im[1][0], A, A, -A, A);
            end
            n_cmp++;
            if (got_re[1][1] != 0 || got_im[1][11] != 0) begin
                n_err++;
                $display("FAIL single_tone upper entries: got %0d,%0d expected 0,0", got_re[1][1], got_im[1][11]);
            end
        end
    endtask
`endif

    initial begin
        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_Qm        = 3'd0;
        bus.i_n_sc      = 2'd0;
        bus.i_bit       = 1'b0;
        bus.i_bit_valid = 1'b0;
        repeat (3) step();
        test_reset();
        rst = 1'b0;
        step();
        test_qpsk_short();
        test_bpsk_back_to_back();
        test_qpsk_gaps();
        test_restart();
        test_reset_mid();
        test_random();
`ifdef MODMAP_SINGLE_TONE_EN
        test_single_tone();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
